fwd_scoreboard: RTL and testbench

- Parametrised successor to the pipeline forwarding unit.
- Tracks in-flight register writes in a per-stage scoreboard of DEPTH post-ID positions.
- For each of NUM_SRC ID-stage source operands, selects which stage result bus to forward from.
- Raises a hazard stall when the youngest matching producer's result is not yet forwardable, e.g. load-use or multi-cycle ops.

---
 rtl/fwd_scoreboard_if.sv | 32 +++
 rtl/fwd_scoreboard.sv | 137 +++++++++++++
 tb/tb_fwd_scoreboard.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_if.sv
// ID-stage operand bundle between the pipeline control and the forwarding
// scoreboard. The master drives the ID-side fields and receives the
// forward selects and the stall request; the scoreboard is the slave.
interface fwd_scoreboard_if #(
    parameter int NUM_SRC = 2,
    parameter int RW      = 5,
    parameter int LW      = 2,
    parameter int SW      = 2
);
    logic                  ext_hold;
    logic                  flush;
    logic                  id_valid;
    logic                  id_wr_en;
    logic [RW-1:0]         id_rd;
    logic [LW-1:0]         id_ready_at;
    logic [NUM_SRC*RW-1:0] id_rs_flat;
    logic [NUM_SRC-1:0]    id_rs_used;
    logic [NUM_SRC*SW-1:0] fw_sel_flat;
    logic                  hazard_stall;

    modport master (
        output ext_hold, flush, id_valid, id_wr_en, id_rd, id_ready_at,
               id_rs_flat, id_rs_used,
        input  fw_sel_flat, hazard_stall
    );

    modport slave (
        input  ext_hold, flush, id_valid, id_wr_en, id_rd, id_ready_at,
               id_rs_flat, id_rs_used,
        output fw_sel_flat, hazard_stall
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight register writes for DEPTH stages
// after ID and, per ID source operand, picks the stage bus to forward from or
// requests a stall when the youngest producer's value is not yet available.
// Optional statistics counters are built when FWD_SCOREBOARD_STATS_EN is
// defined; without it the stat ports are absent and core behaviour is equal.
module fwd_scoreboard #(
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int RW      = 5,
    parameter int LW      = 2,
    parameter int SW      = 2,
    parameter int CNTW    = 16
) (
    input  logic               clk,
    input  logic               nrst,
    fwd_scoreboard_if.slave    sb_if
`ifdef FWD_SCOREBOARD_STATS_EN
    ,
    output logic [CNTW-1:0]    stat_stall_cnt,
    output logic [CNTW-1:0]    stat_fwd_cnt
`endif
);

    // Parameter sanity: ready-at and select fields must be able to hold DEPTH.
    if (LW < $clog2(DEPTH + 1) || SW < $clog2(DEPTH + 1) || CNTW < 1 ||
        DEPTH < 1 || NUM_SRC < 1) begin : g_bad_params
        $error("fwd_scoreboard: inconsistent parameters");
    end

    // Scoreboard state, position 1 = EXE ... position DEPTH = oldest tracked.
    logic [DEPTH:1] r_vld;
    logic [RW-1:0]  r_rd  [1:DEPTH];
    logic [LW-1:0]  r_rdy [1:DEPTH];

    logic [NUM_SRC*SW-1:0] w_fw_sel_flat;
    logic [NUM_SRC-1:0]    w_stall_req;
    logic                  w_hazard;
    logic                  w_load_vld;
    logic [LW-1:0]         w_rdy_in;
    logic [RW-1:0]         w_rs;

    // Per-source producer search; lowest matching position (youngest) wins.
    always_comb begin
        // NOTE: every output of this block gets a default before the loops so
        // no path leaves a value unassigned, which would infer a latch.
        w_fw_sel_flat = '0;
        w_stall_req   = '0;
        w_rs          = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            w_rs = sb_if.id_rs_flat[s*RW +: RW];
            // Walk oldest to youngest so the youngest match overwrites.
            for (int k = DEPTH; k >= 1; k--) begin
                if (sb_if.id_rs_used[s] && (w_rs != '0) && r_vld[k] &&
                    (r_rd[k] == w_rs)) begin
                    if (k >= int'(r_rdy[k])) begin
                        w_fw_sel_flat[s*SW +: SW] = SW'(k);
                        w_stall_req[s]            = 1'b0;
                    end else begin
                        w_fw_sel_flat[s*SW +: SW] = '0;
                        w_stall_req[s]            = 1'b1;
                    end
                end
            end
        end
    end

    // A frozen pipeline already holds ID, so the stall is suppressed then.
    assign w_hazard = (|w_stall_req) & ~sb_if.ext_hold;

    assign sb_if.fw_sel_flat  = w_fw_sel_flat;
    assign sb_if.hazard_stall = w_hazard;

    // Normalise ready-at: 0 means ALU (1), anything beyond DEPTH clamps.
    always_comb begin
        if (sb_if.id_ready_at == '0) begin
            w_rdy_in = LW'(1);
        end else if (int'(sb_if.id_ready_at) > DEPTH) begin
            w_rdy_in = LW'(DEPTH);
        end else begin
            w_rdy_in = sb_if.id_ready_at;
        end
    end

    // Writes to x0 are never tracked; flush or stall inject a bubble.
    assign w_load_vld = sb_if.id_valid & sb_if.id_wr_en &
                        (sb_if.id_rd != '0) & ~sb_if.flush & ~w_hazard;

    // Shift the scoreboard one stage per unheld cycle; oldest entry retires.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_vld <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                r_rd[k]  <= '0;
                r_rdy[k] <= '0;
            end
        end else if (!sb_if.ext_hold) begin
            // NOTE: non-blocking assignments make every position read the
            // pre-edge value of its neighbour, giving a true shift register.
            for (int k = DEPTH; k >= 2; k--) begin
                r_vld[k] <= r_vld[k-1];
                r_rd[k]  <= r_rd[k-1];
                r_rdy[k] <= r_rdy[k-1];
            end
            r_vld[1] <= w_load_vld;
            r_rd[1]  <= sb_if.id_rd;
            r_rdy[1] <= w_rdy_in;
        end
    end

`ifdef FWD_SCOREBOARD_STATS_EN
    logic [CNTW-1:0] r_stall_cnt;
    logic [CNTW-1:0] r_fwd_cnt;
    logic            w_fwd_event;

    assign w_fwd_event = sb_if.id_valid & ~sb_if.flush & ~w_hazard &
                         (|w_fw_sel_flat);

    // Saturating counts of stall cycles and forwarded issues, frozen on hold.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else if (!sb_if.ext_hold) begin
            if (w_hazard && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNTW'(1);
            end
            if (w_fwd_event && (r_fwd_cnt != '1)) begin
                r_fwd_cnt <= r_fwd_cnt + CNTW'(1);
            end
        end
    end

    assign stat_stall_cnt = r_stall_cnt;
    assign stat_fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard at default geometry (2 sources,
// depth 3). Expected selects/stalls come from hand-derived stimulus tables,
// pushed to a queue as each step is driven and popped when sampled.
module tb_fwd_scoreboard;

`ifdef FWD_SCOREBOARD_STATS_EN
    localparam int CNTW_TB = 4;
`else
    localparam int CNTW_TB = 16;
`endif

    logic clk;
    logic nrst;

    fwd_scoreboard_if #(.NUM_SRC(2), .RW(5), .LW(2), .SW(2)) sb_if ();

`ifdef FWD_SCOREBOARD_STATS_EN
    logic [CNTW_TB-1:0] stat_stall_cnt;
    logic [CNTW_TB-1:0] stat_fwd_cnt;
`endif

    fwd_scoreboard #(
        .NUM_SRC(2), .DEPTH(3), .RW(5), .LW(2), .SW(2), .CNTW(CNTW_TB)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .sb_if          (sb_if)
`ifdef FWD_SCOREBOARD_STATS_EN
        ,
        .stat_stall_cnt (stat_stall_cnt),
        .stat_fwd_cnt   (stat_fwd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic       wr;
        logic [4:0] rd;
        logic [1:0] rdy;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [1:0] used;
        logic       hold;
        logic       flush;
        logic [3:0] exp_fw;
        logic       exp_st;
    } step_t;

    typedef struct {
        logic [3:0] fw;
        logic       st;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

`ifdef FWD_SCOREBOARD_STATS_EN
    int model_stall = 0;
    int model_fwd   = 0;
    localparam int CNT_MAX = (1 << CNTW_TB) - 1;
`endif

    function automatic step_t mk(logic v, logic w, int rd, int rdy, int rs0,
                                 int rs1, logic [1:0] used, logic hold,
                                 logic flush, logic [3:0] fw, logic st);
        step_t s;
        s.valid = v;   s.wr = w;         s.rd = 5'(rd);  s.rdy = 2'(rdy);
        s.rs0 = 5'(rs0); s.rs1 = 5'(rs1); s.used = used;
        s.hold = hold; s.flush = flush;  s.exp_fw = fw;  s.exp_st = st;
        return s;
    endfunction

    // Drive one ID step, record its expectation, let combinational paths settle.
    task automatic apply(input step_t s);
        exp_t e;
        sb_if.id_valid    = s.valid;
        sb_if.id_wr_en    = s.wr;
        sb_if.id_rd       = s.rd;
        sb_if.id_ready_at = s.rdy;
        sb_if.id_rs_flat  = {s.rs1, s.rs0};
        sb_if.id_rs_used  = s.used;
        sb_if.ext_hold    = s.hold;
        sb_if.flush       = s.flush;
        e.fw = s.exp_fw;
        e.st = s.exp_st;
        exp_q.push_back(e);
`ifdef FWD_SCOREBOARD_STATS_EN
        if (!s.hold && s.exp_st && model_stall < CNT_MAX) model_stall++;
        if (!s.hold && !s.exp_st && s.valid && !s.flush && s.exp_fw != 4'h0 &&
            model_fwd < CNT_MAX) model_fwd++;
`endif
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        apply_idle();
        repeat (4) tick();
    endtask

    task automatic apply_idle();
        sb_if.id_valid = 0; sb_if.id_wr_en = 0; sb_if.id_rd = '0;
        sb_if.id_ready_at = '0; sb_if.id_rs_flat = '0; sb_if.id_rs_used = '0;
        sb_if.ext_hold = 0; sb_if.flush = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        nrst = 1'b0;
        apply(mk(1, 0, 0, 0, 5, 7, 2'b11, 0, 0, 4'h0, 0));
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (sb_if.fw_sel_flat !== e.fw) begin
            bad++; $display("FAIL reset fw_sel_flat got %b want %b", sb_if.fw_sel_flat, e.fw);
        end
        total++;
        if (sb_if.hazard_stall !== e.st) begin
            bad++; $display("FAIL reset hazard_stall got %b want %b", sb_if.hazard_stall, e.st);
        end
`ifdef FWD_SCOREBOARD_STATS_EN
        total++;
        if (stat_stall_cnt !== '0 || stat_fwd_cnt !== '0) begin
            bad++; $display("FAIL reset stats got %0d/%0d want 0/0", stat_stall_cnt, stat_fwd_cnt);
        end
`endif
        nrst = 1'b1;
        drain();
    endtask

    task automatic test_alu_forward();
        step_t t[$];
        exp_t  e;
        t.push_back(mk(1, 1, 5, 1, 0, 0, 2'b00, 0, 0, 4'h0, 0));
        t.push_back(mk(1, 0, 0, 0, 5, 0, 2'b01, 0, 0, 4'h1, 0));
        t.push_back(mk(1, 0, 0, 0, 5, 0, 2'b01, 0, 0, 4'h2, 0));
        t.push_back(mk(1, 0, 0, 0, 5, 0, 2'b01, 0, 0, 4'h3, 0));
        t.push_back(mk(1, 0, 0, 0, 5, 0, 2'b01, 0, 0, 4'h0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            total++;
            if (sb_if.fw_sel_flat !== e.fw) begin
                bad++; $display("FAIL alu_fwd step %0d fw_sel_flat got %b want %b", i, sb_if.fw_sel_flat, e.fw);
            end
            total++;
            if (sb_if.hazard_stall !== e.st) begin
                bad++; $display("FAIL alu_fwd step %0d hazard_stall got %b want %b", i, sb_if.hazard_stall, e.st);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_load_use();
        step_t t[$];
        exp_t  e;
        t.push_back(mk(1, 1, 7, 2, 0, 0, 2'b00, 0, 0, 4'h0, 0));
        t.push_back(mk(1, 1, 8, 1, 8, 7, 2'b11, 0, 1, 4'h0, 1));
        t.push_back(mk(1, 1, 8, 1, 8, 7, 2'b11, 0, 0, 4'h8, 0));
        t.push_back(mk(1, 0, 0, 0, 8, 7, 2'b11, 0, 0, 4'hD, 0));
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            total++;
            if (sb_if.fw_sel_flat !== e.fw) begin
                bad++; $display("FAIL load_use step %0d fw_sel_flat got %b want %b", i, sb_if.fw_sel_flat, e.fw);
            end
            total++;
            if (sb_if.hazard_stall !== e.st) begin
                bad++; $display("FAIL load_use step %0d hazard_stall got %b want %b", i, sb_if.hazard_stall, e.st);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_youngest();
        step_t t[$];
        exp_t  e;
        t.push_back(mk(1, 1, 3, 0, 0, 0, 2'b00, 0, 0, 4'h0, 0));
        t.push_back(mk(1, 1, 3, 0, 3, 0, 2'b01, 0, 0, 4'h1, 0));
        t.push_back(mk(1, 0, 0, 0, 3, 3, 2'b11, 0, 0, 4'h5, 0));
        t.push_back(mk(1, 0, 0, 0, 0, 3, 2'b01, 0, 0, 4'h0, 0));
        t.push_back(mk(1, 1, 3, 1, 0, 0, 2'b00, 0, 0, 4'h0, 0));
        t.push_back(mk(1, 1, 3, 2, 0, 0, 2'b00, 0, 0, 4'h0, 0));
        t.push_back(mk(1, 0, 0, 0, 0, 3, 2'b10, 0, 0, 4'h0, 1));
        t.push_back(mk(1, 0, 0, 0, 0, 3, 2'b10, 0, 0, 4'h8, 0));
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            total++;
            if (sb_if.fw_sel_flat !== e.fw) begin
                bad++; $display("FAIL youngest step %0d fw_sel_flat got %b want %b", i, sb_if.fw_sel_flat, e.fw);
            end
            total++;
            if (sb_if.hazard_stall !== e.st) begin
                bad++; $display("FAIL youngest step %0d hazard_stall got %b want %b", i, sb_if.hazard_stall, e.st);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_ext_hold();
        step_t t[$];
        exp_t  e;
        t.push_back(mk(1, 1, 7, 2, 0, 0, 2'b00, 0, 0, 4'h0, 0));
        repeat (3) t.push_back(mk(1, 1, 9, 1, 7, 0, 2'b01, 1, 1, 4'h0, 0));
        t.push_back(mk(1, 0, 0, 0, 7, 0, 2'b01, 0, 0, 4'h0, 1));
        t.push_back(mk(1, 0, 0, 0, 7, 9, 2'b11, 0, 0, 4'h2, 0));
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            total++;
            if (sb_if.fw_sel_flat !== e.fw) begin
                bad++; $display("FAIL ext_hold step %0d fw_sel_flat got %b want %b", i, sb_if.fw_sel_flat, e.fw);
            end
            total++;
            if (sb_if.hazard_stall !== e.st) begin
                bad++; $display("FAIL ext_hold step %0d hazard_stall got %b want %b", i, sb_if.hazard_stall, e.st);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_flush_and_reset();
        step_t t[$];
        exp_t  e;
        t.push_back(mk(1, 1, 9, 1, 0, 0, 2'b00, 0, 1, 4'h0, 0));
        t.push_back(mk(1, 0, 0, 0, 9, 9, 2'b11, 0, 0, 4'h0, 0));
        t.push_back(mk(1, 0, 0, 0, 9, 0, 2'b01, 0, 0, 4'h0, 0));
        t.push_back(mk(1, 1, 4, 1, 0, 0, 2'b00, 0, 0, 4'h0, 0));
        t.push_back(mk(1, 1, 6, 2, 4, 0, 2'b01, 0, 0, 4'h1, 0));
        t.push_back(mk(1, 0, 0, 0, 4, 6, 2'b11, 0, 0, 4'h2, 1));
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            total++;
            if (sb_if.fw_sel_flat !== e.fw) begin
                bad++; $display("FAIL flush step %0d fw_sel_flat got %b want %b", i, sb_if.fw_sel_flat, e.fw);
            end
            total++;
            if (sb_if.hazard_stall !== e.st) begin
                bad++; $display("FAIL flush step %0d hazard_stall got %b want %b", i, sb_if.hazard_stall, e.st);
            end
            if (i < t.size() - 1) tick();
        end
        // Asynchronous reset mid-cycle with x4 at pos2 and a load of x6 at pos1.
        nrst = 1'b0;
        e.fw = 4'h0;
        e.st = 1'b0;
        exp_q.push_back(e);
        #1;
`ifdef FWD_SCOREBOARD_STATS_EN
        model_stall = 0;
        model_fwd   = 0;
`endif
        for (int r = 0; r < 2; r++) begin
            e = exp_q.pop_front();
            total++;
            if (sb_if.fw_sel_flat !== e.fw) begin
                bad++; $display("FAIL async_reset phase %0d fw_sel_flat got %b want %b", r, sb_if.fw_sel_flat, e.fw);
            end
            total++;
            if (sb_if.hazard_stall !== e.st) begin
                bad++; $display("FAIL async_reset phase %0d hazard_stall got %b want %b", r, sb_if.hazard_stall, e.st);
            end
            if (r == 0) begin
                tick();
                nrst = 1'b1;
                exp_q.push_back(e);
                #1;
            end
        end
        drain();
    endtask

`ifdef FWD_SCOREBOARD_STATS_EN
    task automatic test_stats();
        step_t t[$];
        exp_t  e;
        for (int n = 0; n < 10; n++) begin
            t.push_back(mk(1, 1, 7, 3, 0, 0, 2'b00, 0, 0, 4'h0, 0));
            t.push_back(mk(1, 0, 0, 0, 7, 0, 2'b01, 0, 0, 4'h0, 1));
            t.push_back(mk(1, 0, 0, 0, 7, 0, 2'b01, 0, 0, 4'h0, 1));
            t.push_back(mk(1, 0, 0, 0, 7, 0, 2'b01, 0, 0, 4'h3, 0));
        end
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            total++;
            if (sb_if.fw_sel_flat !== e.fw || sb_if.hazard_stall !== e.st) begin
                bad++; $display("FAIL stats step %0d fw/stall got %b/%b want %b/%b", i, sb_if.fw_sel_flat, sb_if.hazard_stall, e.fw, e.st);
            end
            tick();
        end
        total++;
        if (stat_stall_cnt !== CNTW_TB'(model_stall) || model_stall != CNT_MAX) begin
            bad++; $display("FAIL stat_stall_cnt got %0d want %0d", stat_stall_cnt, CNT_MAX);
        end
        total++;
        if (stat_fwd_cnt !== CNTW_TB'(model_fwd)) begin
            bad++; $display("FAIL stat_fwd_cnt got %0d want %0d", stat_fwd_cnt, model_fwd);
        end
        drain();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        apply_idle();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_youngest();
        test_ext_hold();
        test_flush_and_reset();
`ifdef FWD_SCOREBOARD_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
